spi_slave_ctrl: RTL and testbench

Parametrised, oversampled SPI slave that deserialises MOSI words of DATA_WIDTH bits in any of the four SPI modes and queues them in an internal FIFO read through a valid/ready port. All SPI pins are synchronised into the system clock, so every output is single-domain. Unlike the single-word predecessor, a frame carries multiple words, and overflow and truncated frames are reported. It sits between the SPI pads and the SoC configuration/register logic.

---
 rtl/spi_slave_pkg.sv | 20 ++
 rtl/spi_slave_fifo.sv | 56 +++++
 rtl/spi_slave_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types, defaults and mode helpers for the oversampled SPI slave.
package spi_slave_pkg;

    localparam int unsigned DEF_DATA_WIDTH  = 32;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    // Data is sampled on the rising SCLK edge when CPOL == CPHA.
    function automatic logic sample_on_rise(input spi_mode_e m);
        return (m == MODE0) || (m == MODE3);
    endfunction

endpackage

// File: rtl/spi_slave_fifo.sv
// First-word-fall-through RX FIFO; head reads as zero while empty.
module spi_slave_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO only succeeds when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// Oversampled multi-word SPI slave with RX FIFO, overflow and frame-error reporting.
// Define SPI_SLAVE_MISO_EN to add the single-entry MISO transmit path.
module spi_slave_ctrl
    import spi_slave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              SCLK,
    input  logic                              SS,
    input  logic                              MOSI,
    input  logic [1:0]                        mode,
    output logic [DATA_WIDTH-1:0]             rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level,
    output logic                              overflow,
    input  logic                              ovf_clr,
`ifdef SPI_SLAVE_MISO_EN
    output logic                              MISO,
    input  logic [DATA_WIDTH-1:0]             tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic                              tx_underrun,
`endif
    output logic                              frame_err
);

    localparam int unsigned CW = $clog2(DATA_WIDTH);

    logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, prime_q;
    logic                   sclk_d1_q, ss_d1_q;
    logic                   samp_q, mosi_q, ss_low_q, ss_rise_q, armed_q;
    logic                   sclk_s, ss_s, on_rise, sclk_rise, sclk_fall;
`ifdef SPI_SLAVE_MISO_EN
    logic                   shft_q, ss_fall_q;
`endif

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign on_rise   = sample_on_rise(spi_mode_e'(mode));
    assign sclk_rise = sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s & sclk_d1_q;

    // Synchronisers plus one registered edge-detect stage; armed_q blocks a frame caught mid-flight at reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            prime_q     <= '0;
            sclk_d1_q   <= 1'b0;
            ss_d1_q     <= 1'b1;
            samp_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ss_low_q    <= 1'b0;
            ss_rise_q   <= 1'b0;
            armed_q     <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
            shft_q      <= 1'b0;
            ss_fall_q   <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            prime_q     <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            sclk_d1_q   <= sclk_s;
            ss_d1_q     <= ss_s;
            samp_q      <= on_rise ? sclk_rise : sclk_fall;
            mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
            ss_low_q    <= ~ss_s;
            ss_rise_q   <= ss_s & ~ss_d1_q;
            if (prime_q[SYNC_STAGES-1] && ss_s) armed_q <= 1'b1;
`ifdef SPI_SLAVE_MISO_EN
            shft_q      <= on_rise ? sclk_fall : sclk_rise;
            ss_fall_q   <= ~ss_s & ss_d1_q;
`endif
        end
    end

    logic [DATA_WIDTH-2:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  frame_err_q, frame_err_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  active, word_done, fifo_full, fifo_empty, fifo_pop;

    assign active    = armed_q & ss_low_q;
    assign word      = {shift_q, mosi_q};
    assign word_done = active & samp_q & (bit_cnt_q == CW'(DATA_WIDTH - 1));
    assign fifo_pop  = rx_ready & ~fifo_empty;

    always_comb begin
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        frame_err_d = 1'b0;
        if (!active) begin
            bit_cnt_d   = '0;
            frame_err_d = ss_rise_q && (bit_cnt_q != '0);
        end else if (samp_q) begin
            shift_d   = word[DATA_WIDTH-2:0];
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
        end
        overflow_d = (word_done & fifo_full & ~fifo_pop) | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    spi_slave_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (word_done),
        .push_data_i (word),
        .pop_i       (rx_ready),
        .head_o      (rx_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (rx_level)
    );

    assign rx_valid  = ~fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

`ifdef SPI_SLAVE_MISO_EN
    logic [DATA_WIDTH-1:0] hold_q, tx_shift_q;
    logic                  hold_full_q, miso_q, tx_underrun_q, tx_start;

    assign tx_start = (armed_q & ss_fall_q) | word_done;

    // MISO re-presents the bit for the current bit_cnt on every shift edge, which suits both CPHA settings.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            tx_shift_q    <= '0;
            miso_q        <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;
            if (tx_start) begin
                tx_shift_q    <= hold_full_q ? hold_q : '0;
                miso_q        <= hold_full_q & hold_q[DATA_WIDTH-1];
                tx_underrun_q <= ~hold_full_q;
                hold_full_q   <= 1'b0;
            end else if (!active) begin
                miso_q <= 1'b0;
            end else if (shft_q) begin
                miso_q <= tx_shift_q[CW'(DATA_WIDTH - 1) - bit_cnt_q];
            end
            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign MISO        = miso_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = tx_underrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Randomised bench for spi_slave_ctrl: a bit-level SPI master and a word-queue reference model.
`timescale 1ns/1ps
module tb_spi_slave_ctrl;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SYN   = 2;
    localparam int unsigned LW    = $clog2(DEPTH + 1);
    localparam int unsigned HP    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          SCLK = 1'b0;
    logic          SS = 1'b1;
    logic          MOSI = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [LW-1:0] rx_level;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic          frame_err;
    logic          miso_w;
`ifdef SPI_SLAVE_MISO_EN
    logic          MISO;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_underrun;
    assign miso_w = MISO;
`else
    assign miso_w = 1'b0;
`endif

    spi_slave_ctrl #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SYN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .SCLK        (SCLK),
        .SS          (SS),
        .MOSI        (MOSI),
        .mode        (mode),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_level    (rx_level),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
`ifdef SPI_SLAVE_MISO_EN
        .MISO        (MISO),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
`endif
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int und_cnt = 0;
    int valid_rise_cyc = -1;
    int last_samp = 0;
    logic prev_valid = 1'b0;

    logic          mosi_bits[$];
    logic          miso_bits[$];
    int            und_snap[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_ovf = 1'b0;
    int            exp_ferr = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = rx_valid;
`ifdef SPI_SLAVE_MISO_EN
        if (tx_underrun) und_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_word(input logic [DW-1:0] w);
        for (int b = DW - 1; b >= 0; b--) mosi_bits.push_back(w[b]);
    endtask

    task automatic add_bits(input int k);
        for (int b = 0; b < k; b++) mosi_bits.push_back(1'($urandom));
    endtask

    // Master: drives mosi_bits in the current mode, records MISO at each sample edge.
    task automatic spi_frame(input bit end_frame);
        logic cpol, cpha;
        int   n;
        cpol = mode[1];
        cpha = mode[0];
        n    = mosi_bits.size();
        miso_bits.delete();
        und_snap.delete();
        SCLK = cpol;
        wait_clk(HP);
        SS = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                MOSI = mosi_bits[i];
                wait_clk(HP);
            end else begin
                SCLK = ~SCLK;
                MOSI = mosi_bits[i];
                wait_clk(HP);
            end
            miso_bits.push_back(miso_w);
            if ((i + 1) % DW == 0) und_snap.push_back(und_cnt);
            SCLK = ~SCLK;
            last_samp = cyc;
            wait_clk(HP);
            if (!cpha) SCLK = ~SCLK;
        end
        if (end_frame) begin
            wait_clk(HP);
            SS = 1'b1;
            wait_clk(HP);
        end
    endtask

    // Reference: every DW bits of a frame form one word; leftover bits are a frame error.
    task automatic model_frame();
        int            n, nw;
        logic [DW-1:0] v;
        n  = mosi_bits.size();
        nw = n / DW;
        for (int w = 0; w < nw; w++) begin
            v = '0;
            for (int b = 0; b < DW; b++) v = (v << 1) | DW'(mosi_bits[w * DW + b]);
            if (exp_q.size() < DEPTH) exp_q.push_back(v);
            else                      exp_ovf = 1'b1;
        end
        if (n % DW != 0) exp_ferr++;
    endtask

    task automatic do_frame();
        spi_frame(1'b1);
        model_frame();
        mosi_bits.delete();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_level"}, 64'(rx_level), 64'(exp_q.size()));
        check({tag, "_valid"}, 64'(rx_valid), 64'(exp_q.size() != 0));
        check({tag, "_ovf"},   64'(overflow), 64'(exp_ovf));
        check({tag, "_ferr"},  64'(ferr_cnt), 64'(exp_ferr));
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) begin
            check({tag, "_hd_valid"}, 64'(rx_valid), 64'd1);
            check({tag, "_hd_data"},  64'(rx_data),  64'(exp_q[0]));
            check({tag, "_hd_level"}, 64'(rx_level), 64'(exp_q.size()));
            rx_ready = 1'b1;
            wait_clk(1);
            rx_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        check({tag, "_empty"}, 64'(rx_valid), 64'd0);
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        wait_clk(1);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 64'(rx_valid),  64'd0);
        check({tag, "_level"}, 64'(rx_level),  64'd0);
        check({tag, "_ovf"},   64'(overflow),  64'd0);
        check({tag, "_ferr"},  64'(frame_err), 64'd0);
        check({tag, "_data"},  64'(rx_data),   64'd0);
`ifdef SPI_SLAVE_MISO_EN
        check({tag, "_miso"},  64'(MISO),      64'd0);
        check({tag, "_txrdy"}, 64'(tx_ready),  64'd1);
        check({tag, "_txund"}, 64'(tx_underrun), 64'd0);
`endif
    endtask

    initial begin
        int            nw, extra;
        logic [DW-1:0] w;
        logic [DW-1:0] edge_w [4];

        edge_w[0] = 32'h0000_0001;
        edge_w[1] = 32'hFFFF_FFFF;
        edge_w[2] = 32'h8000_0000;
        edge_w[3] = 32'h0000_0000;

        wait_clk(3);
        check_reset_vals("rst");
        reset = 1'b1;
        wait_clk(8);

        // Mode 0 single word and push latency.
        mode = 2'b00;
        valid_rise_cyc = -1;
        add_word(32'hA5A5_1234);
        do_frame();
        check("latency", 64'(valid_rise_cyc - last_samp), 64'(SYN + 2));
        check_state("m0");
        drain("m0");

        // Modes 1..3, three back-to-back words per frame.
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            add_word(edge_w[0]);
            add_word(edge_w[1]);
            add_word(edge_w[2]);
            do_frame();
            check_state("b2b");
            drain("b2b");
        end

        // Overflow: five words into a four-deep FIFO.
        mode = 2'b00;
        for (int i = 0; i < 5; i++) add_word(DW'($urandom));
        do_frame();
        check_state("ovf");
        drain("ovf");
        check("ovf_sticky", 64'(overflow), 64'd1);
        clear_ovf();

        // Truncated frame then a clean word.
        mode = 2'b01;
        add_bits(13);
        do_frame();
        check_state("trunc");
        add_word(32'h1357_9BDF);
        do_frame();
        check_state("trunc_next");
        drain("trunc_next");

        // Reset in the middle of a word with two words queued.
        mode = 2'b00;
        add_word(DW'($urandom));
        add_word(DW'($urandom));
        do_frame();
        check_state("prerst");
        add_bits(10);
        spi_frame(1'b0);
        mosi_bits.delete();
        reset = 1'b0;
        wait_clk(2);
        check_reset_vals("midrst");
        exp_q.delete();
        exp_ovf = 1'b0;
        reset = 1'b1;
        wait_clk(10);
        for (int i = 0; i < 14; i++) begin
            MOSI = 1'($urandom);
            SCLK = ~SCLK;
            wait_clk(HP);
        end
        SS = 1'b1;
        wait_clk(HP);
        check_state("postrst");
        add_word(32'hC0FF_EE01);
        do_frame();
        check_state("rst_next");
        drain("rst_next");

`ifdef SPI_SLAVE_MISO_EN
        // Transmit: preloaded word, then an underrun word.
        mode = 2'b00;
        tx_data  = 32'hDEAD_BEEF;
        tx_valid = 1'b1;
        wait_clk(1);
        tx_valid = 1'b0;
        check("txrdy_full", 64'(tx_ready), 64'd0);
        add_word(DW'($urandom));
        add_word(DW'($urandom));
        do_frame();
        w = '0;
        for (int b = 0; b < DW; b++) w = (w << 1) | DW'(miso_bits[b]);
        check("miso_w0", 64'(w), 64'hDEAD_BEEF);
        w = '1;
        for (int b = 0; b < DW; b++) w = (w << 1) | DW'(miso_bits[DW + b]);
        check("miso_w1", 64'(w), 64'h0);
        check("txund_once", 64'(und_snap[1] - und_snap[0]), 64'd1);
        check("txrdy_empty", 64'(tx_ready), 64'd1);
        check_state("tx");
        drain("tx");
`endif

        // Randomised frames across modes, word counts and truncations.
        for (int it = 0; it < 12; it++) begin
            mode  = 2'($urandom);
            nw    = $urandom_range(0, 3);
            extra = ($urandom % 3 == 0) ? $urandom_range(1, DW - 1) : 0;
            if (nw == 0 && extra == 0) nw = 1;
            for (int k = 0; k < nw; k++) begin
                w = ($urandom % 4 == 0) ? edge_w[$urandom % 4] : DW'($urandom);
                add_word(w);
            end
            add_bits(extra);
            do_frame();
            check_state("rnd");
            if (($urandom % 2 == 0) || exp_q.size() >= 3) begin
                drain("rnd");
                if (exp_ovf) clear_ovf();
            end
        end
        drain("final");
        if (exp_ovf) clear_ovf();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
